sim_run_ctrl: RTL and testbench

//   Parametrised run controller for the riscv_top simulation and FPGA harness.
//   It takes one raw board or bench reset, synchronises its release and holds
//   the core in reset for a fixed count. It then releases NUM_DOM reset domains
//   in a staggered order, counts run cycles, ends the run on halt_req, and

---
 rtl/sim_run_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_sim_run_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// sim_run_ctrl
//   Run controller for the riscv_top simulation / FPGA harness. It synchronises
//   the release of one raw reset, holds the core in reset for HOLD_CYCLES, then
//   releases NUM_DOM reset domains one after another, STAGGER cycles apart.
//   Once every domain is out of reset it counts run cycles. The run ends on
//   halt_req (DONE) or when the watchdog expires (TIMEOUT).
//
// Parameters
//   NUM_DOM         number of reset domains (>=1)
//   HOLD_CYCLES     cycles held in reset after the synchronised release (>=1)
//   STAGGER         cycles between consecutive domain releases (0 = all at once)
//   CNT_W           width of cycle_cnt
//   TIMEOUT_CYCLES  watchdog limit in run cycles (0 = watchdog disabled)
//
// Ports
//   clk        in   single clock, posedge
//   rst_n      in   asynchronous active-low reset
//   halt_req   in   program finished; honoured in RUN only
//   pause      in   freezes cycle_cnt and the watchdog while high in RUN
//   dom_rst    out  per-domain active-high reset, bit i drives domain i
//   running    out  high while in RUN
//   done       out  sticky, run ended by halt_req
//   timed_out  out  sticky, watchdog expired
//   cycle_cnt  out  run cycles counted so far, saturating
// -----------------------------------------------------------------------------
module sim_run_ctrl #(
    parameter int NUM_DOM        = 2,
    parameter int HOLD_CYCLES    = 25,
    parameter int STAGGER        = 4,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 150000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               halt_req,
    input  logic               pause,
    output logic [NUM_DOM-1:0] dom_rst,
    output logic               running,
    output logic               done,
    output logic               timed_out,
    output logic [CNT_W-1:0]   cycle_cnt
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STG_W  = (STAGGER > 0) ? $clog2(STAGGER + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'((STAGGER > 0) ? STAGGER - 1 : 0);

    // With a single domain or no stagger gap every domain leaves reset together.
    localparam bit INSTANT = (NUM_DOM == 1) || (STAGGER == 0);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A limit that cycle_cnt can never reach behaves like a disabled watchdog.
    localparam bit                TO_EN  = (TIMEOUT_CYCLES > 0) &&
                                           ((64'(TIMEOUT_CYCLES) >> CNT_W) == 64'd0);
    localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_STAGGER,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [STG_W-1:0]    stag_cnt_q, stag_cnt_d;
    logic [NUM_DOM-1:0]  dom_rst_q, dom_rst_d, dom_shift;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic                timed_out_q, timed_out_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Two-flop synchroniser: assertion is asynchronous, release is
    // seen by the FSM only after the second edge with rst_n high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= '0;
            stag_cnt_q  <= '0;
            dom_rst_q   <= '1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            stag_cnt_q  <= stag_cnt_d;
            dom_rst_q   <= dom_rst_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
            cnt_q       <= cnt_d;
        end
    end

    // Domains release lowest-first: shifting zeros in from the LSB side
    // clears one more bit per release step.
    assign dom_shift = dom_rst_q << 1;
    assign cnt_inc   = sat_inc(cnt_q);

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        stag_cnt_d  = stag_cnt_q;
        dom_rst_d   = dom_rst_q;
        running_d   = running_q;
        done_d      = done_q;
        timed_out_d = timed_out_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            S_HOLD: begin
                if (sync_q[1]) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        if (INSTANT) begin
                            dom_rst_d = '0;
                            running_d = 1'b1;
                            state_d   = S_RUN;
                        end else begin
                            dom_rst_d  = dom_shift;
                            stag_cnt_d = '0;
                            state_d    = S_STAGGER;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end

            S_STAGGER: begin
                if (stag_cnt_q == STG_LAST) begin
                    stag_cnt_d = '0;
                    dom_rst_d  = dom_shift;
                    if (dom_shift == '0) begin
                        running_d = 1'b1;
                        state_d   = S_RUN;
                    end
                end else begin
                    stag_cnt_d = stag_cnt_q + 1'b1;
                end
            end

            S_RUN: begin
                // halt_req has priority over both pause and watchdog expiry.
                if (halt_req) begin
                    done_d    = 1'b1;
                    running_d = 1'b0;
                    state_d   = S_DONE;
                end else if (!pause) begin
                    cnt_d = cnt_inc;
                    if (TO_EN && (cnt_inc == TO_VAL)) begin
                        timed_out_d = 1'b1;
                        running_d   = 1'b0;
                        dom_rst_d   = '1;
                        state_d     = S_TIMEOUT;
                    end
                end
            end

            default: begin
                // DONE and TIMEOUT are terminal until rst_n asserts.
            end
        endcase
    end

    assign dom_rst   = dom_rst_q;
    assign running   = running_q;
    assign done      = done_q;
    assign timed_out = timed_out_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_run_ctrl
//   Self-checking bench for sim_run_ctrl. Instance "a" uses HOLD=5, STAGGER=3,
//   NUM_DOM=3, TIMEOUT=20, CNT_W=8; instance "b" disables the watchdog with a
//   4-bit counter. Expected outputs come from a per-edge reference model keyed
//   on the number of edges since the rst_n release.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sim_run_ctrl;

    localparam int NDOM = 3;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, halt_req, pause;
    logic [2:0] dom_rst;
    logic       running, done, timed_out;
    logic [7:0] cycle_cnt;

    logic       rst_n_b, halt_b, pause_b;
    logic [2:0] dom_rst_b;
    logic       running_b, done_b, timed_out_b;
    logic [3:0] cycle_cnt_b;

    sim_run_ctrl #(
        .NUM_DOM(NDOM), .HOLD_CYCLES(5), .STAGGER(3), .CNT_W(8), .TIMEOUT_CYCLES(20)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .pause(pause),
        .dom_rst(dom_rst), .running(running), .done(done),
        .timed_out(timed_out), .cycle_cnt(cycle_cnt)
    );

    sim_run_ctrl #(
        .NUM_DOM(NDOM), .HOLD_CYCLES(5), .STAGGER(3), .CNT_W(4), .TIMEOUT_CYCLES(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .halt_req(halt_b), .pause(pause_b),
        .dom_rst(dom_rst_b), .running(running_b), .done(done_b),
        .timed_out(timed_out_b), .cycle_cnt(cycle_cnt_b)
    );

    typedef struct packed {
        logic [2:0]  dom;
        logic        running;
        logic        done;
        logic        to;
        logic [31:0] cnt;
    } obs_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected outputs after edge k of a release (k=0: still in reset).
    // Domain release edges 7/10/13, run edges start at 14.
    function automatic obs_t model(input int k, input int halt_e, input int p_s,
                                   input int p_n, input int to, input int cmax);
        obs_t r;
        int   c;
        r.dom     = (k < 7) ? 3'b111 : (k < 10) ? 3'b110 : (k < 13) ? 3'b100 : 3'b000;
        r.running = (k >= 13);
        r.done    = 1'b0;
        r.to      = 1'b0;
        c         = 0;
        for (int e = 14; e <= k; e++) begin
            if (e == halt_e) begin
                r.done    = 1'b1;
                r.running = 1'b0;
                break;
            end
            if (!(e >= p_s && e < p_s + p_n)) begin
                if (c < cmax) c++;
                if (to != 0 && c == to) begin
                    r.to      = 1'b1;
                    r.running = 1'b0;
                    r.dom     = 3'b111;
                    break;
                end
            end
        end
        r.cnt = 32'(c);
        return r;
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o.dom = dom_rst; o.running = running; o.done = done;
        o.to  = timed_out; o.cnt = 32'(cycle_cnt);
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o.dom = dom_rst_b; o.running = running_b; o.done = done_b;
        o.to  = timed_out_b; o.cnt = 32'(cycle_cnt_b);
        return o;
    endfunction

    // Holds rst_n low for two edges and releases it away from the edge,
    // so the next posedge is edge 1.
    task automatic release_a();
        rst_n = 1'b0; halt_req = 1'b0; pause = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives inputs for edge k, queues the expected result, advances one edge.
    task automatic cycle_a(input int k, input int halt_e, input int p_s, input int p_n,
                           input int extra_halt);
        halt_req = (k == halt_e) || (k == extra_halt);
        pause    = (k >= p_s) && (k < p_s + p_n);
        sb.push_back(model(k, halt_e, p_s, p_n, 20, 255));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        rst_n = 1'b0; halt_req = 1'b0; pause = 1'b0;
        rst_n_b = 1'b0; halt_b = 1'b0; pause_b = 1'b0;
        sb.push_back(model(0, -1, 0, 0, 20, 255));
        repeat (2) @(posedge clk);
        #1;
        got = obs_a(); want = sb.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_a: got %p expected %p", got, want);
        end
        sb.push_back(model(0, -1, 0, 0, 0, 15));
        got = obs_b(); want = sb.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_b: got %p expected %p", got, want);
        end
    endtask

    // Release timing; halt_req and pause pulsed before RUN must be ignored.
    task automatic test_release();
        obs_t got, want;
        release_a();
        for (int k = 1; k <= 18; k++) begin
            cycle_a(k, 5, 8, 5, -1);
            got = obs_a(); want = sb.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL release k=%0d: got %p expected %p", k, got, want);
            end
        end
    endtask

    task automatic test_halt();
        obs_t got, want;
        release_a();
        for (int k = 1; k <= 40; k++) begin
            cycle_a(k, 23, 0, 0, 30);
            got = obs_a(); want = sb.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL halt k=%0d: got %p expected %p", k, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t got, want;
        release_a();
        for (int k = 1; k <= 42; k++) begin
            cycle_a(k, -1, 0, 0, -1);
            got = obs_a(); want = sb.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout k=%0d: got %p expected %p", k, got, want);
            end
        end
    endtask

    task automatic test_pause();
        obs_t got, want;
        release_a();
        for (int k = 1; k <= 45; k++) begin
            cycle_a(k, -1, 17, 6, -1);
            got = obs_a(); want = sb.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL pause_to k=%0d: got %p expected %p", k, got, want);
            end
        end
        release_a();
        for (int k = 1; k <= 28; k++) begin
            cycle_a(k, 20, 17, 6, -1);
            got = obs_a(); want = sb.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL pause_halt k=%0d: got %p expected %p", k, got, want);
            end
        end
    endtask

    task automatic test_halt_vs_timeout();
        obs_t got, want;
        release_a();
        for (int k = 1; k <= 38; k++) begin
            cycle_a(k, 33, 0, 0, -1);
            got = obs_a(); want = sb.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL halt_vs_to k=%0d: got %p expected %p", k, got, want);
            end
        end
    endtask

    task automatic test_mid_stagger_reset();
        obs_t got, want;
        release_a();
        for (int k = 1; k <= 8; k++) begin
            cycle_a(k, -1, 0, 0, -1);
            got = obs_a(); want = sb.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL pre_rst k=%0d: got %p expected %p", k, got, want);
            end
        end
        // Assert reset between edges: outputs must change without a clock edge.
        sb.push_back(model(0, -1, 0, 0, 20, 255));
        rst_n = 1'b0;
        #1;
        got = obs_a(); want = sb.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_rst: got %p expected %p", got, want);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cycle_a(k, -1, 0, 0, -1);
            got = obs_a(); want = sb.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL re_release k=%0d: got %p expected %p", k, got, want);
            end
        end
    endtask

    task automatic test_saturate();
        obs_t got, want;
        rst_n_b = 1'b0; halt_b = 1'b0; pause_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n_b = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            sb.push_back(model(k, -1, 0, 0, 0, 15));
            @(posedge clk);
            #1;
            got = obs_b(); want = sb.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL saturate k=%0d: got %p expected %p", k, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_halt();
        test_timeout();
        test_pause();
        test_halt_vs_timeout();
        test_mid_stagger_reset();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
